// File: rtl/operand_entry_seq.sv
// Operand-entry sequencer for the 4-bit divider: button conditioning,
// operand registers, and result capture around a combinational divider.
module operand_entry_seq #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_i,
    input  logic             btn_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] r_i,
    input  logic             err_i,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             err_o,
    output logic             res_valid_o,
    output logic [1:0]       state_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_s;
    logic [CW-1:0]          db_cnt_q, db_cnt_d;
    logic                   db_lvl_q, db_lvl_d;
    logic                   db_dly_q, db_dly_d;
    logic                   press;

    state_t                 state_q, state_d;

    logic [WIDTH-1:0]       op_a_q, op_a_d;
    logic [WIDTH-1:0]       op_b_q, op_b_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic                   err_q, err_d;
    logic                   vld_q, vld_d;

    assign btn_s = sync_q[SYNC_STAGES-1];
    assign press = db_lvl_q & ~db_dly_q;

    // Synchroniser shift and debounce: a level change must persist
    // DB_CYCLES consecutive cycles before it is accepted.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], btn_i};
        db_lvl_d = db_lvl_q;
        db_cnt_d = '0;
        db_dly_d = db_lvl_q;
        if (btn_s != db_lvl_q) begin
            if (db_cnt_q == CW'(DB_CYCLES - 1)) begin
                db_lvl_d = btn_s;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + CW'(1);
            end
        end
    end

    // Input conditioning registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
            db_dly_q <= db_dly_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: presses advance entry, EXEC lasts one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_A:    if (press) state_d = S_B;
            S_B:    if (press) state_d = S_EXEC;
            S_EXEC: state_d = S_SHOW;
            S_SHOW: if (press) state_d = S_A;
            default: state_d = S_A;
        endcase
    end

    // FSM outputs: operand loads and result capture
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        err_d  = err_q;
        vld_d  = vld_q;
        unique case (state_q)
            S_A: begin
                if (press) begin
                    op_a_d = sw_i;
                    vld_d  = 1'b0;
                end
            end
            S_B: begin
                if (press) begin
                    op_b_d = sw_i;
                end
            end
            S_EXEC: begin
                quo_d = q_i;
                rem_d = r_i;
                err_d = err_i;
                vld_d = 1'b1;
            end
            S_SHOW: begin
            end
            default: begin
            end
        endcase
    end

    // Operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q <= '0;
            op_b_q <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            err_q  <= err_d;
            vld_q  <= vld_d;
        end
    end

    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign quo_o       = quo_q;
    assign rem_o       = rem_q;
    assign err_o       = err_q;
    assign res_valid_o = vld_q;
    assign state_o     = state_q;

endmodule
